button_press_decoder: RTL and testbench

BUTTON_PRESS_DECODER -- requirements
Module: button_press_decoder

---
 rtl/button_press_decoder.sv | 90 +++++++++
 tb/tb_button_press_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/button_press_decoder.sv
// button_press_decoder: synchronizes and debounces an active-low pushbutton, then reports
// its debounced level, a short-press pulse on release, a long-press pulse, and a held flag.
module button_press_decoder #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic long_pulse,
  output logic held
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, PRESSED, LONG_HELD, DEB_RELEASE} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic origin_long, origin_n, press_n, long_n, btn_act;
  assign btn_act = ~sync[1];
  always_comb begin
    state_n  = state;
    deb_n    = deb_cnt;
    hold_n   = hold_cnt;
    origin_n = origin_long;
    press_n  = 1'b0;
    long_n   = 1'b0;
    case (state)
      IDLE: if (btn_act) begin
        state_n = DEB_PRESS;
        deb_n   = '0;
      end
      DEB_PRESS: if (!btn_act) state_n = IDLE;
        else if (deb_cnt == DEB_MAX) begin
          state_n = PRESSED;
          hold_n  = '0;
        end else deb_n = deb_cnt + 1'b1;
      PRESSED: if (!btn_act) begin
          state_n  = DEB_RELEASE;
          deb_n    = '0;
          origin_n = 1'b0;
        end else if (hold_cnt == HOLD_MAX) begin
          state_n = LONG_HELD;
          long_n  = 1'b1;
        end else hold_n = hold_cnt + 1'b1;
      LONG_HELD: if (!btn_act) begin
        state_n  = DEB_RELEASE;
        deb_n    = '0;
        origin_n = 1'b1;
      end
      DEB_RELEASE: if (btn_act) begin
          state_n = origin_long ? LONG_HELD : PRESSED;
          deb_n   = '0;
        end else if (deb_cnt == DEB_MAX) begin
          state_n = IDLE;
          press_n = !origin_long;
        end else deb_n = deb_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next-state decode so they align with the state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync        <= 2'b11;
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      origin_long <= 1'b0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      held        <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_raw};
      state       <= state_n;
      deb_cnt     <= deb_n;
      hold_cnt    <= hold_n;
      origin_long <= origin_n;
      btn_level   <= state_n inside {PRESSED, LONG_HELD, DEB_RELEASE};
      press_pulse <= press_n;
      long_pulse  <= long_n;
      held        <= state_n == LONG_HELD || (state_n == DEB_RELEASE && origin_n);
    end
  end
endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder: scoreboard bench; scenarios push timed output events,
// a negedge monitor pops and compares every observed output edge or pulse.
module tb_button_press_decoder;
  localparam int LRISE = 0, LFALL = 1, HRISE = 2, HFALL = 3, PRESS = 4, LONG = 5;
  typedef struct {int cyc; int kind;} ev_t;
  logic clk = 0, rst = 0, btn_raw = 1;
  logic btn_level, press_pulse, long_pulse, held;
  logic p_lvl = 0, p_held = 0, p_press = 0, p_long = 0;
  int cyc = 0, checks = 0, errors = 0;
  ev_t q[$];
  button_press_decoder #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .long_pulse(long_pulse), .held(held)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [5:0] ev;
    ev_t e;
    if (rst) begin
      ev = {long_pulse & !p_long, press_pulse & !p_press, p_held & !held,
            held & !p_held, p_lvl & !btn_level, btn_level & !p_lvl};
      for (int k = 0; k < 6; k++) if (ev[k]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard unexpected event kind %0d at cycle %0d, required none", k, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind !== k || e.cyc !== cyc) begin
            errors++;
            $display("FAIL scoreboard event kind %0d cycle %0d, required kind %0d cycle %0d", k, cyc, e.kind, e.cyc);
          end
        end
      end
      if ((press_pulse && (p_press || p_long)) || (long_pulse && (p_long || p_press))) begin
        checks++;
        errors++;
        $display("FAIL pulse_spacing press %b long %b after press %b long %b, required no consecutive pulses", press_pulse, long_pulse, p_press, p_long);
      end
    end
    {p_lvl, p_held, p_press, p_long} = {btn_level, held, press_pulse, long_pulse};
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input int c, input int k);
    q.push_back('{c, k});
  endtask
  task automatic test_reset;
    step(3);
    checks++;
    if ({btn_level, press_pulse, long_pulse, held} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b, required 0000", {btn_level, press_pulse, long_pulse, held});
    end
    rst = 1;
    step(5);
    checks++;
    if ({btn_level, press_pulse, long_pulse, held} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle got %b, required 0000", {btn_level, press_pulse, long_pulse, held});
    end
  endtask
  task automatic test_short_press;
    btn_raw = 0;
    push(cyc + 7, LRISE);
    step(15);
    btn_raw = 1;
    push(cyc + 7, LFALL);
    push(cyc + 7, PRESS);
    step(12);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL short_press pending %0d events, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic test_bounce;
    for (int i = 0; i < 15; i++) begin
      btn_raw = i[0];
      step(2);
    end
    btn_raw = 1;
    step(10);
    checks++;
    if (q.size() != 0 || {btn_level, press_pulse, long_pulse, held} !== 4'b0) begin
      errors++;
      $display("FAIL bounce outputs %b pending %0d, required 0000 and 0", {btn_level, press_pulse, long_pulse, held}, q.size());
      q.delete();
    end
  endtask
  task automatic test_long_press;
    btn_raw = 0;
    push(cyc + 7, LRISE);
    push(cyc + 27, HRISE);
    push(cyc + 27, LONG);
    step(40);
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL long_held got %b, required 1", held);
    end
    btn_raw = 1;
    push(cyc + 7, LFALL);
    push(cyc + 7, HFALL);
    step(12);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL long_press pending %0d events, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic test_release_bounce;
    int c0;
    c0 = cyc;
    btn_raw = 0;
    push(c0 + 7, LRISE);
    push(c0 + 30, HRISE);
    push(c0 + 30, LONG);
    step(10);
    btn_raw = 1;
    step(2);
    btn_raw = 0;
    step(6);
    checks++;
    if (btn_level !== 1'b1 || held !== 1'b0) begin
      errors++;
      $display("FAIL release_bounce level %b held %b, required 1 0", btn_level, held);
    end
    step(17);
    btn_raw = 1;
    push(cyc + 7, LFALL);
    push(cyc + 7, HFALL);
    step(12);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL release_bounce pending %0d events, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic test_mid_reset;
    btn_raw = 0;
    push(cyc + 7, LRISE);
    step(10);
    #2 rst = 0;
    btn_raw = 1;
    #1;
    checks++;
    if ({btn_level, press_pulse, long_pulse, held} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_async got %b, required 0000", {btn_level, press_pulse, long_pulse, held});
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({btn_level, press_pulse, long_pulse, held} !== 4'b0) begin
        errors++;
        $display("FAIL mid_reset_hold got %b, required 0000", {btn_level, press_pulse, long_pulse, held});
      end
    end
    rst = 1;
    step(15);
    checks++;
    if (q.size() != 0 || {btn_level, press_pulse, long_pulse, held} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_after outputs %b pending %0d, required 0000 and 0", {btn_level, press_pulse, long_pulse, held}, q.size());
      q.delete();
    end
  endtask
  task automatic test_held_through_reset;
    btn_raw = 0;
    #2 rst = 0;
    step(3);
    rst = 1;
    push(cyc + 7, LRISE);
    step(10);
    btn_raw = 1;
    push(cyc + 7, LFALL);
    push(cyc + 7, PRESS);
    step(12);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL held_through_reset pending %0d events, required 0", q.size());
      q.delete();
    end
  endtask
  initial begin
    test_reset;
    test_short_press;
    test_bounce;
    test_long_press;
    test_release_bounce;
    test_mid_reset;
    test_held_through_reset;
    test_short_press;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
